// File: rtl/vdp_pkg.sv
// Shared VDP definitions: CPU pending-op encoding and default VRAM size.
package vdp_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_WRITE = 2'd1,
      OP_FETCH = 2'd2
   } cpu_op_e;

   localparam int VDP_VRAM_SIZE = 8 * 1024;

endpackage

// File: rtl/vdp_vram_ram.sv
// Single-port synchronous VRAM: registered read (read-first), write enable.
module vdp_vram_ram
   import vdp_pkg::*;
#(
   parameter int DEPTH = VDP_VRAM_SIZE,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          pxclk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge pxclk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/vdp_vram_ctl.sv
// VRAM arbiter: display DMA reads with fixed 1-cycle latency, CPU port in idle slots.
// Optional stall counter enabled by defining VDP_VRAM_STALL_CNT_EN.
module vdp_vram_ctl
   import vdp_pkg::*;
#(
   parameter int VRAM_SIZE       = VDP_VRAM_SIZE,
   parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
   input  logic                       pxclk,
   input  logic                       reset_n,
   input  logic [VRAM_ADDR_WIDTH-1:0] vdp_dma_addr,
   input  logic                       vdp_dma_rd_tick,
   output logic [7:0]                 vram_dout,
   input  logic [VRAM_ADDR_WIDTH-1:0] cpu_addr_in,
   input  logic                       cpu_addr_ld_tick,
   input  logic                       cpu_addr_rd,
   input  logic                       cpu_wr_tick,
   input  logic [7:0]                 cpu_din,
   input  logic                       cpu_rd_tick,
   output logic [7:0]                 cpu_dout,
   output logic                       cpu_busy,
   output logic                       cpu_overrun,
   output logic [15:0]                stall_cnt
);

   cpu_op_e                    pend;
   logic [VRAM_ADDR_WIDTH-1:0] cpu_addr;
   logic [7:0]                 wr_data;
   logic                       dma_q;
   logic                       fetch_q;
   logic [7:0]                 vram_hold;
   logic [7:0]                 cpu_hold;
   logic                       overrun_r;

   logic                       busy;
   logic                       exec;
   logic                       ram_we;
   logic [VRAM_ADDR_WIDTH-1:0] ram_addr;
   logic [7:0]                 ram_rdata;

   // An address load in the slot cycle cancels the pending op instead of running it.
   always_comb begin
      busy     = (pend != OP_NONE);
      exec     = busy && !vdp_dma_rd_tick && !cpu_addr_ld_tick;
      ram_we   = exec && (pend == OP_WRITE);
      ram_addr = vdp_dma_rd_tick ? vdp_dma_addr : cpu_addr;
   end

   vdp_vram_ram #(
      .DEPTH (VRAM_SIZE),
      .AW    (VRAM_ADDR_WIDTH)
   ) u_ram (
      .pxclk (pxclk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (wr_data),
      .rdata (ram_rdata)
   );

   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         pend      <= OP_NONE;
         cpu_addr  <= '0;
         wr_data   <= '0;
         dma_q     <= 1'b0;
         fetch_q   <= 1'b0;
         vram_hold <= '0;
         cpu_hold  <= '0;
         overrun_r <= 1'b0;
      end else begin
         dma_q   <= vdp_dma_rd_tick;
         fetch_q <= exec && (pend == OP_FETCH);
         if (dma_q) begin
            vram_hold <= ram_rdata;
         end
         if (fetch_q) begin
            cpu_hold <= ram_rdata;
         end

         if (exec) begin
            pend     <= OP_NONE;
            cpu_addr <= cpu_addr + VRAM_ADDR_WIDTH'(1);
         end

         // Request handling overrides slot completion; an address load overrides both.
         if (cpu_addr_ld_tick) begin
            cpu_addr  <= cpu_addr_in;
            overrun_r <= 1'b0;
            pend      <= cpu_addr_rd ? OP_FETCH : OP_NONE;
         end else if (cpu_wr_tick || cpu_rd_tick) begin
            if (busy) begin
               overrun_r <= 1'b1;
            end else if (cpu_wr_tick) begin
               pend    <= OP_WRITE;
               wr_data <= cpu_din;
               if (cpu_rd_tick) begin
                  overrun_r <= 1'b1;
               end
            end else begin
               pend <= OP_FETCH;
            end
         end
      end
   end

   assign vram_dout   = dma_q ? ram_rdata : vram_hold;
   assign cpu_dout    = fetch_q ? ram_rdata : cpu_hold;
   assign cpu_busy    = busy;
   assign cpu_overrun = overrun_r;

`ifdef VDP_VRAM_STALL_CNT_EN
   logic [15:0] stall_r;

   always_ff @(posedge pxclk or negedge reset_n) begin
      if (!reset_n) begin
         stall_r <= '0;
      end else if (cpu_addr_ld_tick) begin
         stall_r <= '0;
      end else if (busy && vdp_dma_rd_tick && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end
   end

   assign stall_cnt = stall_r;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_vdp_vram_ctl.sv
// Self-checking bench for vdp_vram_ctl: vector table, directed corner sequences, random vs. model.
module tb_vdp_vram_ctl;

   localparam int AW   = 13;
   localparam int SIZE = 8192;
`ifdef VDP_VRAM_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic          pxclk = 1'b0;
   logic          reset_n;
   logic [AW-1:0] vdp_dma_addr;
   logic          vdp_dma_rd_tick;
   logic [7:0]    vram_dout;
   logic [AW-1:0] cpu_addr_in;
   logic          cpu_addr_ld_tick;
   logic          cpu_addr_rd;
   logic          cpu_wr_tick;
   logic [7:0]    cpu_din;
   logic          cpu_rd_tick;
   logic [7:0]    cpu_dout;
   logic          cpu_busy;
   logic          cpu_overrun;
   logic [15:0]   stall_cnt;

   int checks = 0;
   int errors = 0;

   vdp_vram_ctl dut (
      .pxclk            (pxclk),
      .reset_n          (reset_n),
      .vdp_dma_addr     (vdp_dma_addr),
      .vdp_dma_rd_tick  (vdp_dma_rd_tick),
      .vram_dout        (vram_dout),
      .cpu_addr_in      (cpu_addr_in),
      .cpu_addr_ld_tick (cpu_addr_ld_tick),
      .cpu_addr_rd      (cpu_addr_rd),
      .cpu_wr_tick      (cpu_wr_tick),
      .cpu_din          (cpu_din),
      .cpu_rd_tick      (cpu_rd_tick),
      .cpu_dout         (cpu_dout),
      .cpu_busy         (cpu_busy),
      .cpu_overrun      (cpu_overrun),
      .stall_cnt        (stall_cnt)
   );

   always #5 pxclk = ~pxclk;

   typedef struct {
      logic          dma;
      logic [AW-1:0] daddr;
      logic          ld;
      logic          lrd;
      logic [AW-1:0] ain;
      logic          wr;
      logic [7:0]    din;
      logic          rd;
      logic [7:0]    e_vd;
      logic [7:0]    e_cd;
      logic          e_busy;
      logic          e_ovr;
   } vec_t;

   vec_t vecs[$];

   // Reference model state (spec-level view of the CPU port and memory)
   logic [7:0] m_mem [SIZE];
   bit         m_kn  [SIZE];
   logic [7:0] m_vd, m_cd, m_lat;
   bit         m_vdk, m_cdk, m_ovr;
   int         m_addr, m_pend, m_stall;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv(input logic dma, input logic [AW-1:0] daddr, input logic ld, input logic lrd,
                      input logic [AW-1:0] ain, input logic wr, input logic [7:0] din, input logic rd);
      vdp_dma_rd_tick  = dma;
      vdp_dma_addr     = daddr;
      cpu_addr_ld_tick = ld;
      cpu_addr_rd      = lrd;
      cpu_addr_in      = ain;
      cpu_wr_tick      = wr;
      cpu_din          = din;
      cpu_rd_tick      = rd;
   endtask

   task automatic tick();
      @(negedge pxclk);
   endtask

   function automatic void addv(input logic dma, input logic [AW-1:0] daddr, input logic ld,
                                input logic lrd, input logic [AW-1:0] ain, input logic wr,
                                input logic [7:0] din, input logic rd, input logic [7:0] vd,
                                input logic [7:0] cd, input logic busy, input logic ovr);
      vec_t v;
      v.dma = dma; v.daddr = daddr; v.ld = ld; v.lrd = lrd; v.ain = ain;
      v.wr = wr; v.din = din; v.rd = rd;
      v.e_vd = vd; v.e_cd = cd; v.e_busy = busy; v.e_ovr = ovr;
      vecs.push_back(v);
   endfunction

   task automatic mstep(input logic dma, input logic [AW-1:0] daddr, input logic ld, input logic lrd,
                        input logic [AW-1:0] ain, input logic wr, input logic [7:0] din, input logic rd);
      bit busy, exec;
      drv(dma, daddr, ld, lrd, ain, wr, din, rd);
      busy = (m_pend != 0);
      exec = busy && !dma && !ld;
      if (dma) begin
         m_vd  = m_mem[daddr];
         m_vdk = m_kn[daddr];
      end
      if (exec) begin
         if (m_pend == 2) begin
            m_cd  = m_mem[m_addr];
            m_cdk = m_kn[m_addr];
         end else begin
            m_mem[m_addr] = m_lat;
            m_kn[m_addr]  = 1'b1;
         end
         m_addr = (m_addr + 1) % SIZE;
         m_pend = 0;
      end
      if (STALL_EN && !ld && busy && dma && m_stall < 65535) m_stall++;
      if (ld) begin
         m_addr  = int'(ain);
         m_ovr   = 1'b0;
         m_pend  = lrd ? 2 : 0;
         m_stall = 0;
      end else if (wr || rd) begin
         if (busy) m_ovr = 1'b1;
         else if (wr) begin
            m_pend = 1;
            m_lat  = din;
            if (rd) m_ovr = 1'b1;
         end else m_pend = 2;
      end
      tick();
      if (m_vdk) chk("rand vram_dout", 32'(vram_dout), 32'(m_vd));
      if (m_cdk) chk("rand cpu_dout", 32'(cpu_dout), 32'(m_cd));
      chk("rand cpu_busy", 32'(cpu_busy), 32'(m_pend != 0));
      chk("rand cpu_overrun", 32'(cpu_overrun), 32'(m_ovr));
      chk("rand stall_cnt", 32'(stall_cnt), 32'(m_stall));
   endtask

   function automatic logic [AW-1:0] win_addr();
      return AW'((SIZE - 4 + int'($urandom_range(0, 7))) % SIZE);
   endfunction

   initial begin
      reset_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      reset_n = 1'b1;
      tick();
      chk("reset vram_dout", 32'(vram_dout), 0);
      chk("reset cpu_dout", 32'(cpu_dout), 0);
      chk("reset cpu_busy", 32'(cpu_busy), 0);
      chk("reset cpu_overrun", 32'(cpu_overrun), 0);
      chk("reset stall_cnt", 32'(stall_cnt), 0);

      // DMA latency and hold: preload 0x0123 through the CPU port
      drv(0, 0, 1, 0, 13'h0123, 0, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 1, 8'hA5, 0); tick();
      chk("preload busy", 32'(cpu_busy), 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("preload busy drop", 32'(cpu_busy), 0);
      drv(1, 13'h0123, 0, 0, 0, 0, 0, 0); tick();
      chk("dma N+1", 32'(vram_dout), 32'h A5);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk($sformatf("dma hold N+%0d", i), 32'(vram_dout), 32'hA5);
      end

      // Vector table: dma daddr ld lrd ain wr din rd | vram_dout cpu_dout busy overrun
      addv(0, 0, 1, 0, 13'h0010, 0, 0, 0,       8'hA5, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h11, 0,          8'hA5, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'hA5, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h22, 0,          8'hA5, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'hA5, 8'h00, 0, 0);
      addv(1, 13'h0010, 0, 0, 0, 0, 0, 0,       8'h11, 8'h00, 0, 0);
      addv(1, 13'h0011, 0, 0, 0, 0, 0, 0,       8'h22, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h22, 8'h00, 0, 0);
      addv(0, 0, 1, 0, 13'h1FFF, 0, 0, 0,       8'h22, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h33, 0,          8'h22, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h22, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h44, 0,          8'h22, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h22, 8'h00, 0, 0);
      addv(1, 13'h1FFF, 0, 0, 0, 0, 0, 0,       8'h33, 8'h00, 0, 0);
      addv(1, 13'h0000, 0, 0, 0, 0, 0, 0,       8'h44, 8'h00, 0, 0);
      addv(0, 0, 1, 0, 13'h0200, 0, 0, 0,       8'h44, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h5A, 0,          8'h44, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h44, 8'h00, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h6B, 0,          8'h44, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h44, 8'h00, 0, 0);
      addv(0, 0, 1, 1, 13'h0200, 0, 0, 0,       8'h44, 8'h00, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h44, 8'h5A, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 1,              8'h44, 8'h5A, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h44, 8'h6B, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h77, 0,          8'h44, 8'h6B, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h44, 8'h6B, 0, 0);
      addv(1, 13'h0202, 0, 0, 0, 0, 0, 0,       8'h77, 8'h6B, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h99, 0,          8'h77, 8'h6B, 1, 0);
      addv(0, 0, 0, 0, 0, 1, 8'hAA, 0,          8'h77, 8'h6B, 0, 1);
      addv(1, 13'h0203, 0, 0, 0, 0, 0, 0,       8'h99, 8'h6B, 0, 1);
      addv(0, 0, 1, 0, 13'h0300, 1, 8'h55, 0,   8'h99, 8'h6B, 0, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h99, 8'h6B, 0, 0);
      addv(0, 0, 0, 0, 0, 1, 8'h12, 1,          8'h99, 8'h6B, 1, 1);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h99, 8'h6B, 0, 1);
      addv(1, 13'h0300, 0, 0, 0, 0, 0, 0,       8'h12, 8'h6B, 0, 1);
      addv(0, 0, 1, 1, 13'h0202, 0, 0, 1,       8'h12, 8'h6B, 1, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 0,              8'h12, 8'h77, 0, 0);

      foreach (vecs[i]) begin
         drv(vecs[i].dma, vecs[i].daddr, vecs[i].ld, vecs[i].lrd, vecs[i].ain,
             vecs[i].wr, vecs[i].din, vecs[i].rd);
         tick();
         chk($sformatf("vec%0d vram_dout", i), 32'(vram_dout), 32'(vecs[i].e_vd));
         chk($sformatf("vec%0d cpu_dout", i), 32'(cpu_dout), 32'(vecs[i].e_cd));
         chk($sformatf("vec%0d cpu_busy", i), 32'(cpu_busy), 32'(vecs[i].e_busy));
         chk($sformatf("vec%0d cpu_overrun", i), 32'(cpu_overrun), 32'(vecs[i].e_ovr));
      end

      // Write deferred by a 10-cycle DMA burst
      drv(0, 0, 1, 0, 13'h0400, 0, 0, 0); tick();
      chk("stall cleared by load", 32'(stall_cnt), 0);
      drv(1, 13'h0010, 0, 0, 0, 1, 8'hC3, 0); tick();
      chk("burst req busy", 32'(cpu_busy), 1);
      chk("burst req vram_dout", 32'(vram_dout), 32'h11);
      for (int i = 0; i < 10; i++) begin
         drv(1, (i % 2 == 0) ? 13'h0011 : 13'h0010, 0, 0, 0, 0, 0, 0); tick();
         chk($sformatf("burst%0d busy", i), 32'(cpu_busy), 1);
         chk($sformatf("burst%0d vram_dout", i), 32'(vram_dout), (i % 2 == 0) ? 32'h22 : 32'h11);
      end
      chk("burst stall_cnt", 32'(stall_cnt), STALL_EN ? 32'd10 : 32'd0);
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
      chk("burst write slot busy", 32'(cpu_busy), 0);
      chk("burst vram_dout kept", 32'(vram_dout), 32'h11);
      drv(1, 13'h0400, 0, 0, 0, 0, 0, 0); tick();
      chk("burst write landed", 32'(vram_dout), 32'hC3);

      // Async reset during a pending write
      drv(0, 0, 1, 0, 13'h0500, 0, 0, 0); tick();
      drv(0, 0, 0, 0, 0, 1, 8'h5C, 0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0); tick();
      drv(0, 0, 1, 0, 13'h0500, 0, 0, 0); tick();
      drv(1, 13'h0010, 0, 0, 0, 1, 8'hE1, 0); tick();
      chk("rst pre busy", 32'(cpu_busy), 1);
      drv(1, 13'h0011, 0, 0, 0, 1, 8'hE2, 0); tick();
      chk("rst pre overrun", 32'(cpu_overrun), 1);
      chk("rst pre vram_dout", 32'(vram_dout), 32'h22);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      chk("async rst vram_dout", 32'(vram_dout), 0);
      chk("async rst cpu_dout", 32'(cpu_dout), 0);
      chk("async rst cpu_busy", 32'(cpu_busy), 0);
      chk("async rst cpu_overrun", 32'(cpu_overrun), 0);
      chk("async rst stall_cnt", 32'(stall_cnt), 0);
      tick(); tick();
      reset_n = 1'b1;
      drv(1, 13'h0500, 0, 0, 0, 0, 0, 0); tick();
      chk("rst write dropped", 32'(vram_dout), 32'h5C);
      chk("rst busy after", 32'(cpu_busy), 0);

      // Random phase against the reference model
      for (int i = 0; i < SIZE; i++) begin
         m_mem[i] = '0;
         m_kn[i]  = 1'b0;
      end
      m_vd = 8'h5C; m_vdk = 1'b1; m_cd = 8'h00; m_cdk = 1'b1; m_lat = '0;
      m_ovr = 1'b0; m_addr = 0; m_pend = 0; m_stall = 0;
      mstep(0, 0, 1, 0, 13'h1FFC, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         mstep(0, 0, 0, 0, 0, 1, 8'($urandom_range(0, 255)), 0);
         mstep(0, 0, 0, 0, 0, 0, 0, 0);
      end
      for (int i = 0; i < 600; i++) begin
         mstep(1'($urandom_range(0, 1)), win_addr(), ($urandom_range(0, 9) == 0),
               1'($urandom_range(0, 1)), win_addr(), ($urandom_range(0, 3) == 0),
               8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vdp_vram_ctl.md
Name: vdp_vram_ctl

Overview:
- VRAM responder for the VDP display pipeline. Owns the VRAM array and services vdp_dma_rd_tick/vdp_dma_addr reads from the gfx and sprite FSMs with fixed 1-cycle latency.
- Also provides a TMS9918-style CPU access port: auto-increment address register, write path, and read-ahead buffer.
- CPU operations slot into idle cycles where there is no DMA tick. Display fetches are never delayed.

Parameters:
- VRAM_SIZE, 8*1024: bytes of VRAM; must be a power of 2.
- VRAM_ADDR_WIDTH, $clog2(VRAM_SIZE): address width.

Ports:
- pxclk  in  1  pixel/system clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- vdp_dma_addr  in  VRAM_ADDR_WIDTH  display fetch address.
- vdp_dma_rd_tick  in  1  display fetch request, one cycle per read.
- vram_dout  out  8  display fetch data.
- cpu_addr_in  in  VRAM_ADDR_WIDTH  new CPU address.
- cpu_addr_ld_tick  in  1  load CPU address register.
- cpu_addr_rd  in  1  qualifies cpu_addr_ld_tick: 1 = schedule read-ahead of the loaded address.
- cpu_wr_tick  in  1  write cpu_din at the CPU address, then increment.
- cpu_din  in  8  CPU write data.
- cpu_rd_tick  in  1  consume cpu_dout, then fetch the next address.
- cpu_dout  out  8  read-ahead buffer.
- cpu_busy  out  1  CPU op pending, not yet executed.
- cpu_overrun  out  1  sticky: a CPU op arrived while busy.
- stall_cnt  out  16  cycles a pending CPU op was deferred by DMA (optional feature).

Behaviour:
- Reset (async assert, sync release):
  - vram_dout=0, cpu_dout=0, cpu_busy=0, cpu_overrun=0, stall_cnt=0.
  - CPU address=0, pending op=NONE.
  - VRAM contents are not cleared.
- DMA read:
  - When vdp_dma_rd_tick=1 in cycle N, vram_dout = mem[vdp_dma_addr] from cycle N+1.
  - vram_dout holds until the next DMA read completes.
  - CPU activity never changes vram_dout. Implement with a one-cycle-delayed source flag: RAM read register when the last access was DMA, otherwise the held copy.
- Arbitration:
  - Single shared RAM port.
  - Cycle with vdp_dma_rd_tick=1 is a DMA cycle; any other cycle is a CPU slot.
  - DMA has absolute priority.
- Pending op register, one entry. Op states: NONE, WRITE, FETCH.
  - cpu_wr_tick: pending=WRITE; cpu_din is latched.
  - cpu_rd_tick: pending=FETCH.
  - cpu_addr_ld_tick: address := cpu_addr_in; cpu_overrun cleared.
    - cpu_addr_rd=1: pending=FETCH.
    - cpu_addr_rd=0: pending=NONE; cancels any pending op.
  - cpu_busy = (pending != NONE), visible the cycle after the request tick.
- Execution, in the first CPU slot after the request cycle:
  - WRITE: mem[addr] := latched data; addr := addr+1.
  - FETCH: cpu_dout := mem[addr], valid 1 cycle after the slot; addr := addr+1.
  - pending returns to NONE in the slot cycle; cpu_busy drops the next cycle.
- Address increment wraps modulo VRAM_SIZE, so 0x1FFF+1 = 0x0000 at default size.
- Collisions:
  - cpu_wr_tick or cpu_rd_tick while cpu_busy=1: request ignored, cpu_overrun := 1. Its data is discarded; pending op unchanged.
  - Simultaneous cpu_wr_tick and cpu_rd_tick: write wins, overrun set.
  - cpu_addr_ld_tick together with wr or rd tick: address load wins; the other tick is ignored, overrun not set.
- Long DMA bursts: a pending op may wait indefinitely; the CPU polls cpu_busy.
- cpu_dout is stable except at FETCH completion.

Optional Feature:
- Macro: VDP_VRAM_STALL_CNT_EN.
- Defined:
  - stall_cnt increments, saturating at 0xFFFF, every cycle with cpu_busy=1 and vdp_dma_rd_tick=1.
  - Cleared on cpu_addr_ld_tick.
- Undefined: stall_cnt tied to 0; no counter logic.

Decomposition:
- Shared package vdp_pkg:
  - Pending-op encoding: OP_NONE=2'd0, OP_WRITE=2'd1, OP_FETCH=2'd2.
  - Default VRAM_SIZE constant.
- Natural sub-module: vdp_vram_ram, single-port synchronous RAM with registered read and write enable, so it infers a single BRAM.
- Arbiter and CPU port logic stay in vdp_vram_ctl.

Test Plan:
- Preload mem[0x0123]=0xA5; DMA tick addr 0x0123 in cycle N -> vram_dout=0xA5 at N+1; still 0xA5 at N+5 with no ticks.
- Load address 0x0010 with rd=0; write 0x11, 0x22 with idle gaps; DMA-read 0x0010, 0x0011 -> 0x11, 0x22.
- Load address 0x1FFF with rd=0; write 0x33, 0x44 -> mem[0x1FFF]=0x33, mem[0x0000]=0x44 (wrap).
- Write pending while DMA ticks for 10 consecutive cycles:
  - cpu_busy=1 throughout; write lands in the first non-DMA cycle.
  - vram_dout carries only DMA data.
  - stall_cnt=10 with VDP_VRAM_STALL_CNT_EN.
- Load address 0x0200 with rd=1 (mem[0x0200]=0x5A, mem[0x0201]=0x6B):
  - cpu_dout=0x5A after busy drops.
  - cpu_rd_tick -> cpu_dout=0x6B; address now 0x0202.
- Second cpu_wr_tick while busy -> ignored, cpu_overrun=1; cleared by cpu_addr_ld_tick.
- Async reset_n low mid-pending-write -> write never occurs; all outputs 0 immediately.
